// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers: fixed-latency MULT/MULTU/DIV/DIVU
// plus single-cycle MTHI/MTLO moves.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    op_e         op_in;
    op_e         op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [15:0] count;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] div_d;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    assign op_in = op_e'(op);

    // Signed divide works on magnitudes, so 0x80000000 / -1 wraps back to
    // 0x80000000 naturally; a zero divisor is replaced to keep the divider defined.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        a_neg  = (op_q == OP_DIV) && a_q[31];
        b_neg  = (op_q == OP_DIV) && b_q[31];
        a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
        div_d  = (b_mag == '0) ? 32'd1 : b_mag;
        q_mag  = a_mag / div_d;
        r_mag  = a_mag % div_d;
        res_hi = hi;
        res_lo = lo;
        res_wr = 1'b0;
        case (op_q)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_wr = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
                res_hi = a_neg ? (~r_mag + 32'd1) : r_mag;
                res_wr = (b_q != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_MULT;
        end else if (busy) begin
            count <= count - 16'd1;
            if (count == 16'd1) begin
                busy <= 1'b0;
                if (res_wr) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
        end else if (start) begin
            case (op_in)
                OP_MULT, OP_MULTU: begin
                    a_q   <= rs_data;
                    b_q   <= rt_data;
                    op_q  <= op_in;
                    busy  <= 1'b1;
                    count <= 16'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    a_q   <= rs_data;
                    b_q   <= rt_data;
                    op_q  <= op_in;
                    busy  <= 1'b1;
                    count <= 16'(DIV_CYCLES);
                end
                OP_MTHI: hi <= rs_data;
                OP_MTLO: lo <= rs_data;
                default: ;
            endcase
        end
    end

endmodule
